// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: pipeline hazard controller for the IF/ID and ID/EX boundary.
//
// Detects load-use hazards between the instruction in IF/ID and a load in EX.
// Inserts LOAD_STALL_CYCLES bubbles for each hazard. Flushes for FLUSH_CYCLES
// cycles when EX resolves a taken branch or jump. A redirect always wins over
// a load-use stall.
//
// Parameters:
//   LOAD_STALL_CYCLES  1..3  bubbles per load-use hazard
//   FLUSH_CYCLES       1..3  bubbles per taken branch/jump
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   id_inst[31:0]      instruction in IF/ID
//   ex_mem_read        instruction in EX is a load
//   ex_rd[4:0]         destination register of instruction in EX
//   ex_redirect        branch taken / jump resolved in EX this cycle
//   pc_write           PC update enable
//   if_id_write        IF/ID load enable
//   if_id_flush        clear IF/ID to NOP
//   id_ex_bubble       load NOP into ID/EX
//   busy               controller is in a multi-cycle stall or flush
//
// Optional feature, enabled by defining ID_HAZARD_PERF_EN:
//   stall_count[31:0]  saturating count of load-use bubble cycles
//   flush_count[31:0]  saturating count of redirect bubble cycles
module id_hazard_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES      = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] id_inst,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_redirect,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        busy
`ifdef ID_HAZARD_PERF_EN
    ,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
`endif
);

    typedef enum logic [1:0] {StRun, StLuStall, StBrFlush} state_e;

    // Counter value on entry. It counts the bubbles that remain after the
    // entry cycle.
    localparam logic [1:0] LuLoad = 2'(LOAD_STALL_CYCLES - 1);
    localparam logic [1:0] FlLoad = 2'(FLUSH_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    logic [6:0] opcode;
    logic [4:0] rs1, rs2;
    logic       use_rs1, use_rs2;
    logic       lu_hit;
    logic       flush_evt, stall_evt;

    assign opcode = id_inst[6:0];
    assign rs1    = id_inst[19:15];
    assign rs2    = id_inst[24:20];

    // Immediate and funct bits play no part in hazard detection.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{id_inst[31:25], id_inst[14:7]};

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            7'b0110011, 7'b0100011, 7'b1100011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111: use_rs1 = 1'b1;
            default: ;
        endcase
    end

    // ex_rd != 0 already excludes an x0 source from matching.
    assign lu_hit = ex_mem_read && (ex_rd != 5'd0) &&
                    ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        flush_evt = 1'b0;
        stall_evt = 1'b0;

        unique case (state_q)
            StRun: begin
                if (ex_redirect) begin
                    flush_evt = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = StBrFlush;
                        cnt_d   = FlLoad;
                    end
                end else if (lu_hit) begin
                    stall_evt = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d = StLuStall;
                        cnt_d   = LuLoad;
                    end
                end
            end
            StLuStall: begin
                if (ex_redirect) begin
                    // Abandon the stall: the stalled instruction is on the
                    // wrong path anyway.
                    flush_evt = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = StBrFlush;
                        cnt_d   = FlLoad;
                    end else begin
                        state_d = StRun;
                    end
                end else begin
                    stall_evt = 1'b1;
                    if (cnt_q <= 2'd1) state_d = StRun;
                    else               cnt_d   = cnt_q - 2'd1;
                end
            end
            StBrFlush: begin
                flush_evt = 1'b1;
                if (ex_redirect)        cnt_d   = FlLoad;
                else if (cnt_q <= 2'd1) state_d = StRun;
                else                    cnt_d   = cnt_q - 2'd1;
            end
            default: state_d = StRun;
        endcase

        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (flush_evt) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (stall_evt) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
        busy = (state_q != StRun);

        // Hold the front end quiet while reset is asserted.
        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            busy         = 1'b0;
            flush_evt    = 1'b0;
            stall_evt    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StRun;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ID_HAZARD_PERF_EN
    logic [31:0] stall_count_q, flush_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count_q <= 32'd0;
            flush_count_q <= 32'd0;
        end else begin
            if (stall_evt && (stall_count_q != 32'hFFFF_FFFF)) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
            if (flush_evt && (flush_count_q != 32'hFFFF_FFFF)) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Testbench for id_hazard_ctrl. Two instances share one stimulus stream:
// dut_a uses the default configuration (1 stall, 1 flush cycle), and dut_b
// uses 3 stall and 3 flush cycles. Output bundles are packed as
// {pc_write, if_id_write, if_id_flush, id_ex_bubble, busy}.
module tb_id_hazard_ctrl;

    localparam logic [4:0] RUN_O = 5'b11000;
    localparam logic [4:0] STL0  = 5'b00010;  // stall, issued from RUN
    localparam logic [4:0] STL1  = 5'b00011;  // stall, inside LU_STALL
    localparam logic [4:0] FL0   = 5'b11110;  // flush, issued from RUN
    localparam logic [4:0] FL1   = 5'b11111;  // flush, inside a busy state
    localparam logic [4:0] RST   = 5'b00110;

    localparam logic [31:0] ADD    = 32'h00728333; // add  x6,x5,x7
    localparam logic [31:0] SW     = 32'h00552A23; // sw   x5,20(x10)
    localparam logic [31:0] LUI    = 32'h000282B7; // lui, bits[19:15]=5
    localparam logic [31:0] ADDI_I = 32'h00510093; // addi x1,x2,5 (rs2 field=5)
    localparam logic [31:0] ADDI_R = 32'h00028093; // addi x1,x5,0
    localparam logic [31:0] BEQ    = 32'h00508063; // beq  x1,x5
    localparam logic [31:0] JALR   = 32'h00028067; // jalr x0,0(x5)

    logic        clk;
    logic        rst_n;
    logic [31:0] id_inst;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        ex_redirect;
    logic        pc_write_a, if_id_write_a, if_id_flush_a, id_ex_bubble_a, busy_a;
    logic        pc_write_b, if_id_write_b, if_id_flush_b, id_ex_bubble_b, busy_b;
`ifdef ID_HAZARD_PERF_EN
    logic [31:0] stall_a, flush_a, stall_b, flush_b;
`endif

    logic [4:0] out_a, out_b;
    assign out_a = {pc_write_a, if_id_write_a, if_id_flush_a, id_ex_bubble_a, busy_a};
    assign out_b = {pc_write_b, if_id_write_b, if_id_flush_b, id_ex_bubble_b, busy_b};

    id_hazard_ctrl #(
        .LOAD_STALL_CYCLES(1),
        .FLUSH_CYCLES     (1)
    ) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_inst     (id_inst),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .ex_redirect (ex_redirect),
        .pc_write    (pc_write_a),
        .if_id_write (if_id_write_a),
        .if_id_flush (if_id_flush_a),
        .id_ex_bubble(id_ex_bubble_a),
        .busy        (busy_a)
`ifdef ID_HAZARD_PERF_EN
        ,
        .stall_count (stall_a),
        .flush_count (flush_a)
`endif
    );

    id_hazard_ctrl #(
        .LOAD_STALL_CYCLES(3),
        .FLUSH_CYCLES     (3)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_inst     (id_inst),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .ex_redirect (ex_redirect),
        .pc_write    (pc_write_b),
        .if_id_write (if_id_write_b),
        .if_id_flush (if_id_flush_b),
        .id_ex_bubble(id_ex_bubble_b),
        .busy        (busy_b)
`ifdef ID_HAZARD_PERF_EN
        ,
        .stall_count (stall_b),
        .flush_count (flush_b)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic [31:0] inst;
        logic        mr;
        logic [4:0]  rd;
        logic        redir;
        logic [4:0]  exp_a;
        logic [4:0]  exp_b;
    } vec_t;

    typedef struct {
        int         idx;
        logic [4:0] a;
        logic [4:0] b;
    } exp_t;

    vec_t vq[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input logic r, input logic [31:0] inst, input logic mr,
                       input logic [4:0] rd, input logic redir,
                       input logic [4:0] ea, input logic [4:0] eb);
        vec_t v;
        v = '{r, inst, mr, rd, redir, ea, eb};
        vq.push_back(v);
    endtask

    task automatic chk5(input string nm, input int idx, input logic [4:0] act,
                        input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec%0d got %b want %b", nm, idx, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare at the
    // falling edge, and return just after the next rising edge.
    task automatic step(input int idx, input logic r, input logic [31:0] inst,
                        input logic mr, input logic [4:0] rd, input logic redir,
                        input logic [4:0] ea, input logic [4:0] eb);
        exp_t e;
        rst_n       = r;
        id_inst     = inst;
        ex_mem_read = mr;
        ex_rd       = rd;
        ex_redirect = redir;
        sb.push_back('{idx, ea, eb});
        @(negedge clk);
        e = sb.pop_front();
        chk5("dut_a", e.idx, out_a, e.a);
        chk5("dut_b", e.idx, out_b, e.b);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fl_a, fl_b, busy_cnt_b, busy_cnt_a;

        rst_n       = 1'b0;
        id_inst     = ADD;
        ex_mem_read = 1'b0;
        ex_rd       = 5'd0;
        ex_redirect = 1'b0;

        //   rst  inst    mr    rd     redir  dut_a  dut_b
        add(1'b0, ADD,    1'b0, 5'd0, 1'b0, RST,   RST);   // 0 reset
        add(1'b1, ADD,    1'b0, 5'd0, 1'b0, RUN_O, RUN_O); // 1
        add(1'b1, ADD,    1'b1, 5'd5, 1'b0, STL0,  STL0);  // 2 load-use via rs1
        add(1'b1, ADD,    1'b0, 5'd5, 1'b0, RUN_O, STL1);  // 3
        add(1'b1, ADD,    1'b0, 5'd5, 1'b0, RUN_O, STL1);  // 4
        add(1'b1, ADD,    1'b0, 5'd5, 1'b0, RUN_O, RUN_O); // 5
        add(1'b1, SW,     1'b1, 5'd5, 1'b0, STL0,  STL0);  // 6 via rs2
        add(1'b1, ADD,    1'b0, 5'd5, 1'b0, RUN_O, STL1);  // 7
        add(1'b1, ADD,    1'b0, 5'd5, 1'b0, RUN_O, STL1);  // 8
        add(1'b1, LUI,    1'b1, 5'd5, 1'b0, RUN_O, RUN_O); // 9 lui uses no source
        add(1'b1, ADD,    1'b1, 5'd0, 1'b0, RUN_O, RUN_O); // 10 ex_rd = x0
        add(1'b1, ADDI_I, 1'b1, 5'd5, 1'b0, RUN_O, RUN_O); // 11 rs2 field unused
        add(1'b1, ADD,    1'b0, 5'd5, 1'b0, RUN_O, RUN_O); // 12 not a load
        add(1'b1, ADD,    1'b0, 5'd5, 1'b1, FL0,   FL0);   // 13 redirect
        add(1'b1, ADD,    1'b0, 5'd5, 1'b0, RUN_O, FL1);   // 14
        add(1'b1, ADD,    1'b0, 5'd5, 1'b0, RUN_O, FL1);   // 15
        add(1'b1, ADD,    1'b0, 5'd5, 1'b0, RUN_O, RUN_O); // 16
        add(1'b1, ADD,    1'b1, 5'd5, 1'b1, FL0,   FL0);   // 17 redirect beats hit
        add(1'b1, ADD,    1'b0, 5'd5, 1'b0, RUN_O, FL1);   // 18
        add(1'b1, ADD,    1'b0, 5'd5, 1'b1, FL0,   FL1);   // 19 reload in flush
        add(1'b1, ADD,    1'b0, 5'd5, 1'b0, RUN_O, FL1);   // 20
        add(1'b1, ADD,    1'b0, 5'd5, 1'b0, RUN_O, FL1);   // 21
        add(1'b1, ADD,    1'b0, 5'd5, 1'b0, RUN_O, RUN_O); // 22
        add(1'b1, JALR,   1'b1, 5'd5, 1'b0, STL0,  STL0);  // 23
        add(1'b1, JALR,   1'b1, 5'd5, 1'b1, FL0,   FL1);   // 24 redirect abandons stall
        add(1'b1, ADD,    1'b0, 5'd5, 1'b0, RUN_O, FL1);   // 25
        add(1'b1, ADD,    1'b0, 5'd5, 1'b0, RUN_O, FL1);   // 26
        add(1'b1, ADD,    1'b0, 5'd5, 1'b0, RUN_O, RUN_O); // 27
        add(1'b1, ADD,    1'b0, 5'd5, 1'b1, FL0,   FL0);   // 28 enter flush, cnt=2
        add(1'b0, ADD,    1'b0, 5'd5, 1'b0, RST,   RST);   // 29 reset mid-flush
        add(1'b1, ADD,    1'b0, 5'd5, 1'b0, RUN_O, RUN_O); // 30 back in RUN
        add(1'b1, BEQ,    1'b1, 5'd5, 1'b0, STL0,  STL0);  // 31
        add(1'b1, ADD,    1'b0, 5'd5, 1'b0, RUN_O, STL1);  // 32
        add(1'b1, ADD,    1'b0, 5'd5, 1'b0, RUN_O, STL1);  // 33
        add(1'b1, ADD,    1'b0, 5'd5, 1'b0, RUN_O, RUN_O); // 34
        add(1'b1, ADDI_R, 1'b1, 5'd5, 1'b0, STL0,  STL0);  // 35 rs1-only opcode
        add(1'b1, ADD,    1'b0, 5'd5, 1'b0, RUN_O, STL1);  // 36
        add(1'b1, ADD,    1'b0, 5'd5, 1'b0, RUN_O, STL1);  // 37
        add(1'b1, ADD,    1'b0, 5'd5, 1'b0, RUN_O, RUN_O); // 38

        @(posedge clk);
        #1;
        for (int i = 0; i < vq.size(); i++) begin
            step(i, vq[i].rst, vq[i].inst, vq[i].mr, vq[i].rd, vq[i].redir,
                 vq[i].exp_a, vq[i].exp_b);
        end

        // A single redirect pulse: count the flush and busy cycles that follow.
        fl_a = 0; fl_b = 0; busy_cnt_a = 0; busy_cnt_b = 0;
        ex_mem_read = 1'b0;
        ex_redirect = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (if_id_flush_a && id_ex_bubble_a) fl_a++;
            if (if_id_flush_b && id_ex_bubble_b) fl_b++;
            if (busy_a) busy_cnt_a++;
            if (busy_b) busy_cnt_b++;
            @(posedge clk);
            #1;
            ex_redirect = 1'b0;
        end
        chk32("flush_cycles_a", fl_a, 1);
        chk32("flush_cycles_b", fl_b, 3);
        chk32("busy_cycles_a", busy_cnt_a, 0);
        chk32("busy_cycles_b", busy_cnt_b, 2);

        // Reset, then four load-use events and one redirect.
        step(100, 1'b0, ADD, 1'b0, 5'd5, 1'b0, RST, RST);
`ifdef ID_HAZARD_PERF_EN
        chk32("stall_count_a_rst", stall_a, 0);
        chk32("flush_count_a_rst", flush_a, 0);
        chk32("stall_count_b_rst", stall_b, 0);
        chk32("flush_count_b_rst", flush_b, 0);
`endif
        for (int k = 0; k < 4; k++) begin
            step(101 + 3 * k, 1'b1, ADD, 1'b1, 5'd5, 1'b0, STL0, STL0);
            step(102 + 3 * k, 1'b1, ADD, 1'b0, 5'd5, 1'b0, RUN_O, STL1);
            step(103 + 3 * k, 1'b1, ADD, 1'b0, 5'd5, 1'b0, RUN_O, STL1);
        end
`ifdef ID_HAZARD_PERF_EN
        chk32("stall_count_a", stall_a, 4);
        chk32("stall_count_b", stall_b, 12);
        chk32("flush_count_a_idle", flush_a, 0);
        chk32("flush_count_b_idle", flush_b, 0);
`endif
        step(120, 1'b1, ADD, 1'b0, 5'd5, 1'b1, FL0, FL0);
        step(121, 1'b1, ADD, 1'b0, 5'd5, 1'b0, RUN_O, FL1);
        step(122, 1'b1, ADD, 1'b0, 5'd5, 1'b0, RUN_O, FL1);
        step(123, 1'b1, ADD, 1'b0, 5'd5, 1'b0, RUN_O, RUN_O);
`ifdef ID_HAZARD_PERF_EN
        chk32("flush_count_a", flush_a, 1);
        chk32("flush_count_b", flush_b, 3);
        chk32("stall_count_b_hold", stall_b, 12);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
